// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle load/store control unit:
// RV64I opcode/funct constants, FSM state enum and decoded instruction class.
package controle_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    localparam logic [2:0] F3_LD    = 3'b011;
    localparam logic [2:0] F3_SD    = 3'b011;
    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_ADD   = 3'b000;

    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } estado_t;

    typedef enum logic [2:0] {
        C_LD, C_SD, C_ADD, C_SUB, C_ADDI, C_ILL
    } classe_t;

endpackage

// File: rtl/decodificador.sv
// Combinational instruction decoder.
// Ports:
//   instr  in  32 : instruction held in IR
//   classe out    : opcode class (C_ILL for any unsupported encoding)
//   rs1/rs2/rd out 5 : register indices; fields unused by the class read as 0
//   imm    out 64 : sign-extended I- or S-type immediate, 0 otherwise
module decodificador
    import controle_pkg::*;
(
    input  logic [31:0] instr,
    output classe_t     classe,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [63:0] imm
);

    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        classe = C_ILL;
        rs1    = '0;
        rs2    = '0;
        rd     = '0;
        imm    = '0;
        case (instr[6:0])
            OP_LOAD: if (f3 == F3_LD) begin
                classe = C_LD;
                rs1    = instr[19:15];
                rd     = instr[11:7];
                imm    = {{52{instr[31]}}, instr[31:20]};
            end
            OP_STORE: if (f3 == F3_SD) begin
                classe = C_SD;
                rs1    = instr[19:15];
                rs2    = instr[24:20];
                imm    = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_OPIMM: if (f3 == F3_ADDI) begin
                classe = C_ADDI;
                rs1    = instr[19:15];
                rd     = instr[11:7];
                imm    = {{52{instr[31]}}, instr[31:20]};
            end
            OP_OP: if (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) begin
                classe = (f7 == F7_SUB) ? C_SUB : C_ADD;
                rs1    = instr[19:15];
                rs2    = instr[24:20];
                rd     = instr[11:7];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit for the 64-bit load/store datapath (ld, sd, add,
// sub, addi). All outputs are registered except pc_next.
// Ports:
//   clk, rst_n (async, active-low), run (level: fetch/execute while high)
//   instr (IR output), pc (PC output), pc_next = pc + 4
//   wePC, weIR, weReg, weMem : one-cycle write enables
//   sinal (0 add / 1 sub), sinalMux1 (0 imm / 1 Rb), sinalMux2 (0 mem / 1 adder)
//   Ra, Rb, Rw, imm : decoded operands, halted, instret (retired count)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for run
// S_FETCH  | IR and PC written this cycle
// S_DECODE | IR valid; fields captured at the end of this cycle
// S_EXEC   | adder operands selected
// S_MEM    | sd writes memory (retires); ld read cycle
// S_WB     | register write-back (retires)
// S_HALT   | illegal instruction seen; left only by reset
module unidade_controle
    import controle_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic [63:0] pc,
    output logic [63:0] pc_next,
    output logic        wePC,
    output logic        weIR,
    output logic        weReg,
    output logic        weMem,
    output logic        sinal,
    output logic        sinalMux1,
    output logic        sinalMux2,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic [4:0]  Rw,
    output logic [63:0] imm,
    output logic        halted,
    output logic [31:0] instret
);

    estado_t     state, state_d;
    classe_t     classe_q;
    classe_t     dec_classe;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [63:0] dec_imm;
    // Set on the first edge after reset, so a run already high at release
    // produces its first FETCH on the second edge.
    logic        pronto;
    logic        retire;
    logic        we_pc_d, we_ir_d, we_reg_d, we_mem_d;

    assign pc_next = pc + 64'd4;

    decodificador u_dec (
        .instr  (instr),
        .classe (dec_classe),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .imm    (dec_imm)
    );

    always_comb begin
        state_d = state;
        retire  = 1'b0;
        case (state)
            S_IDLE:   if (run && pronto) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (dec_classe == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (classe_q == C_LD || classe_q == C_SD) ? S_MEM : S_WB;
            S_MEM: begin
                if (classe_q == C_SD) begin
                    retire  = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // Enables are registered against the state being entered, so each
        // one is high exactly while the FSM sits in the matching state.
        we_pc_d  = (state_d == S_FETCH);
        we_ir_d  = (state_d == S_FETCH);
        we_mem_d = (state_d == S_MEM) && (classe_q == C_SD);
        we_reg_d = (state_d == S_WB) && (Rw != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pronto <= 1'b0;
            wePC   <= 1'b0;
            weIR   <= 1'b0;
            weReg  <= 1'b0;
            weMem  <= 1'b0;
        end else begin
            state  <= state_d;
            pronto <= 1'b1;
            wePC   <= we_pc_d;
            weIR   <= we_ir_d;
            weReg  <= we_reg_d;
            weMem  <= we_mem_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            classe_q  <= C_ILL;
            Ra        <= '0;
            Rb        <= '0;
            Rw        <= '0;
            imm       <= '0;
            sinal     <= 1'b0;
            sinalMux1 <= 1'b0;
            sinalMux2 <= 1'b0;
            halted    <= 1'b0;
            instret   <= '0;
        end else begin
            // Decoded fields and selects are held from here to retirement.
            if (state == S_DECODE && dec_classe != C_ILL) begin
                classe_q  <= dec_classe;
                Ra        <= dec_rs1;
                Rb        <= dec_rs2;
                Rw        <= dec_rd;
                imm       <= dec_imm;
                sinal     <= (dec_classe == C_SUB);
                sinalMux1 <= (dec_classe == C_ADD) || (dec_classe == C_SUB);
                sinalMux2 <= (dec_classe != C_LD);
            end
            if (state_d == S_HALT) halted <= 1'b1;
            if (retire) instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic        wePC, weIR, weReg, weMem;
    logic        sinal, sinalMux1, sinalMux2;
    logic [4:0]  Ra, Rb, Rw;
    logic [63:0] imm;
    logic        halted;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    unidade_controle dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .instr     (instr),
        .pc        (pc),
        .pc_next   (pc_next),
        .wePC      (wePC),
        .weIR      (weIR),
        .weReg     (weReg),
        .weMem     (weMem),
        .sinal     (sinal),
        .sinalMux1 (sinalMux1),
        .sinalMux2 (sinalMux2),
        .Ra        (Ra),
        .Rb        (Rb),
        .Rw        (Rw),
        .imm       (imm),
        .halted    (halted),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; instr = 32'h0; pc = 64'h0;
        #3;
        checks++; if ({wePC, weIR, weReg, weMem} !== 4'b0000) begin errors++; $display("FAIL reset_enables got %b exp 0000", {wePC, weIR, weReg, weMem}); end
        checks++; if ({sinal, sinalMux1, sinalMux2, halted} !== 4'b0000) begin errors++; $display("FAIL reset_selects got %b exp 0000", {sinal, sinalMux1, sinalMux2, halted}); end
        checks++; if ({Ra, Rb, Rw} !== 15'd0) begin errors++; $display("FAIL reset_regs got %h exp 0", {Ra, Rb, Rw}); end
        checks++; if (imm !== 64'd0) begin errors++; $display("FAIL reset_imm got %h exp 0", imm); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
        tick(); rst_n = 1'b1;
        tick(); tick();
        checks++; if (weIR !== 1'b0) begin errors++; $display("FAIL idle_no_fetch got %b exp 0", weIR); end
    endtask

    task automatic test_pc_next();
        pc = 64'h100; #1;
        checks++; if (pc_next !== 64'h104) begin errors++; $display("FAIL pc_next got %h exp 104", pc_next); end
        pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        checks++; if (pc_next !== 64'h0) begin errors++; $display("FAIL pc_next_wrap got %h exp 0", pc_next); end
        pc = 64'h0;
    endtask

    task automatic test_ld();
        instr = 32'h00003083; run = 1'b1;
        tick(); // cycle 1
        checks++; if ({weIR, wePC} !== 2'b11) begin errors++; $display("FAIL ld_fetch got %b exp 11", {weIR, wePC}); end
        run = 1'b0;
        tick(); // cycle 2
        checks++; if ({weIR, wePC} !== 2'b00) begin errors++; $display("FAIL ld_fetch_single got %b exp 00", {weIR, wePC}); end
        tick(); // cycle 3
        checks++; if ({Ra, Rw} !== {5'd0, 5'd1}) begin errors++; $display("FAIL ld_regs got Ra=%0d Rw=%0d exp 0 1", Ra, Rw); end
        checks++; if (imm !== 64'd0 || sinalMux1 !== 1'b0) begin errors++; $display("FAIL ld_imm_mux1 got %h %b exp 0 0", imm, sinalMux1); end
        tick(); // cycle 4
        checks++; if ({weReg, weMem} !== 2'b00) begin errors++; $display("FAIL ld_mem got %b exp 00", {weReg, weMem}); end
        tick(); // cycle 5
        checks++; if ({weReg, sinalMux2} !== 2'b10) begin errors++; $display("FAIL ld_wb got %b exp 10", {weReg, sinalMux2}); end
        tick();
        checks++; if (instret !== 32'd1 || weReg !== 1'b0) begin errors++; $display("FAIL ld_retire got %0d %b exp 1 0", instret, weReg); end
    endtask

    task automatic test_back_to_back();
        instr = 32'h001101B3; run = 1'b1;
        tick(); tick(); tick(); // EXEC of add
        checks++; if ({Ra, Rb, Rw} !== {5'd2, 5'd1, 5'd3}) begin errors++; $display("FAIL add_regs got %0d %0d %0d exp 2 1 3", Ra, Rb, Rw); end
        checks++; if ({sinalMux1, sinal, sinalMux2} !== 3'b101) begin errors++; $display("FAIL add_sel got %b exp 101", {sinalMux1, sinal, sinalMux2}); end
        instr = 32'h40308233;
        tick(); // cycle 4 WB
        checks++; if (weReg !== 1'b1) begin errors++; $display("FAIL add_wb got %b exp 1", weReg); end
        tick(); // FETCH of sub, no idle cycle
        checks++; if (weIR !== 1'b1 || instret !== 32'd2) begin errors++; $display("FAIL sub_fetch got %b %0d exp 1 2", weIR, instret); end
        tick(); tick(); // EXEC of sub
        checks++; if ({Ra, Rb, Rw} !== {5'd1, 5'd3, 5'd4}) begin errors++; $display("FAIL sub_regs got %0d %0d %0d exp 1 3 4", Ra, Rb, Rw); end
        checks++; if ({sinalMux1, sinal} !== 2'b11) begin errors++; $display("FAIL sub_sel got %b exp 11", {sinalMux1, sinal}); end
        run = 1'b0;
        tick();
        checks++; if ({weReg, sinalMux2} !== 2'b11) begin errors++; $display("FAIL sub_wb got %b exp 11", {weReg, sinalMux2}); end
        tick();
        checks++; if (instret !== 32'd3 || weIR !== 1'b0) begin errors++; $display("FAIL sub_retire got %0d %b exp 3 0", instret, weIR); end
    endtask

    task automatic test_sd();
        logic reg_seen;
        reg_seen = 1'b0;
        instr = 32'h0062B423; run = 1'b1;
        tick(); run = 1'b0; reg_seen |= weReg;
        tick(); reg_seen |= weReg;
        tick(); reg_seen |= weReg;
        checks++; if ({Ra, Rb} !== {5'd5, 5'd6} || imm !== 64'd8) begin errors++; $display("FAIL sd_fields got %0d %0d %h exp 5 6 8", Ra, Rb, imm); end
        checks++; if (weMem !== 1'b0) begin errors++; $display("FAIL sd_mem_early got %b exp 0", weMem); end
        tick(); reg_seen |= weReg;
        checks++; if (weMem !== 1'b1) begin errors++; $display("FAIL sd_mem got %b exp 1", weMem); end
        tick(); reg_seen |= weReg;
        checks++; if (weMem !== 1'b0 || instret !== 32'd4) begin errors++; $display("FAIL sd_retire got %b %0d exp 0 4", weMem, instret); end
        tick(); reg_seen |= weReg;
        checks++; if (reg_seen !== 1'b0) begin errors++; $display("FAIL sd_no_wereg got %b exp 0", reg_seen); end
    endtask

    task automatic test_addi();
        instr = 32'hFFD00393; run = 1'b1;
        tick(); tick(); tick();
        checks++; if (imm !== 64'hFFFF_FFFF_FFFF_FFFD || Rw !== 5'd7 || sinalMux2 !== 1'b1) begin errors++; $display("FAIL addi_fields got %h %0d %b exp fffffffffffffffd 7 1", imm, Rw, sinalMux2); end
        instr = 32'h00100013;
        tick();
        checks++; if (weReg !== 1'b1) begin errors++; $display("FAIL addi_wb got %b exp 1", weReg); end
        tick(); run = 1'b0;
        tick(); tick();
        checks++; if (Rw !== 5'd0 || imm !== 64'd1) begin errors++; $display("FAIL addi_x0_fields got %0d %h exp 0 1", Rw, imm); end
        tick();
        checks++; if (weReg !== 1'b0) begin errors++; $display("FAIL addi_x0_wereg got %b exp 0", weReg); end
        tick();
        checks++; if (instret !== 32'd6) begin errors++; $display("FAIL addi_x0_instret got %0d exp 6", instret); end
    endtask

    task automatic test_illegal();
        logic any_en;
        any_en = 1'b0;
        instr = 32'h00000000; run = 1'b1;
        tick(); tick();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ill_early got %b exp 0", halted); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_halted got %b exp 1", halted); end
        for (int i = 0; i < 20; i++) begin
            tick();
            any_en |= wePC | weIR | weReg | weMem;
        end
        checks++; if (any_en !== 1'b0 || halted !== 1'b1 || instret !== 32'd6) begin errors++; $display("FAIL ill_absorb got en=%b h=%b n=%0d exp 0 1 6", any_en, halted, instret); end
        rst_n = 1'b0; run = 1'b0; #1;
        checks++; if (halted !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL ill_reset got %b %0d exp 0 0", halted, instret); end
        tick(); rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_abort_sd();
        instr = 32'h0062B423; run = 1'b1;
        tick(); run = 1'b0;
        tick(); tick(); tick();
        checks++; if (weMem !== 1'b1) begin errors++; $display("FAIL abort_mem got %b exp 1", weMem); end
        #2 rst_n = 1'b0; #1;
        checks++; if (weMem !== 1'b0) begin errors++; $display("FAIL abort_async got %b exp 0", weMem); end
        tick();
        checks++; if (weMem !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL abort_after got %b %0d exp 0 0", weMem, instret); end
    endtask

    task automatic test_simul_release();
        instr = 32'h001101B3;
        rst_n = 1'b1; run = 1'b1;
        tick();
        checks++; if (weIR !== 1'b0) begin errors++; $display("FAIL release_edge1 got %b exp 0", weIR); end
        tick();
        checks++; if (weIR !== 1'b1) begin errors++; $display("FAIL release_edge2 got %b exp 1", weIR); end
        run = 1'b0;
        tick(); tick(); tick();
        checks++; if (weReg !== 1'b1) begin errors++; $display("FAIL release_wb got %b exp 1", weReg); end
        tick();
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL release_instret got %0d exp 1", instret); end
    endtask

    task automatic test_run_drop();
        logic refetch;
        refetch = 1'b0;
        instr = 32'h001101B3; run = 1'b1;
        tick(); tick(); tick(); // EXEC
        run = 1'b0;
        tick();
        checks++; if (weReg !== 1'b1) begin errors++; $display("FAIL drop_wb got %b exp 1", weReg); end
        for (int i = 0; i < 5; i++) begin
            tick();
            refetch |= wePC | weIR;
        end
        checks++; if (refetch !== 1'b0 || instret !== 32'd2) begin errors++; $display("FAIL drop_idle got %b %0d exp 0 2", refetch, instret); end
    endtask

    initial begin
        test_reset();
        test_pc_next();
        test_ld();
        test_back_to_back();
        test_sd();
        test_addi();
        test_illegal();
        test_abort_sd();
        test_simul_release();
        test_run_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the 64-bit load/store datapath: register bank, data memory, adder, Mux1/Mux2, instruction memory, PC and IR. Drives every control signal of that datapath from the instruction held in IR, sequencing fetch, decode, execute, memory and write-back through an FSM. Supports `ld`, `sd`, `add`, `sub` and `addi` (RV64I encodings). Halts on any other encoding.

## Interface
- No parameters. Data width is fixed at 64 bits and instruction width at 32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level-sensitive. While high, the unit fetches and executes instructions.
- `instr` in 32: IR output (`doutIR`).
- `pc` in 64: PC output.
- `pc_next` out 64: `pc + 4`, modulo 2^64. Feeds PC `data_in`.
- `wePC`, `weIR`, `weReg`, `weMem` out 1 each: write enables.
- `sinal` out 1: adder operation. 0 = add, 1 = subtract.
- `sinalMux1` out 1: adder B select. 0 = `imm`, 1 = register Rb.
- `sinalMux2` out 1: register write-data select. 0 = memory `dout`, 1 = adder result.
- `Ra`, `Rb`, `Rw` out 5 each: register indices. Zero-extended at the top level.
- `imm` out 64: sign-extended immediate.
- `halted` out 1: set when an illegal instruction is decoded.
- `instret` out 32: retired-instruction counter.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **IDLE:** go to FETCH when `run`=1.
- **FETCH:** `weIR`=1 and `wePC`=1 for exactly this cycle. Next state is DECODE.
- **DECODE:** register the opcode class, `Ra`=rs1, `Rb`=rs2, `Rw`=rd and `imm`.
  - I-type: `imm` = `sext(instr[31:20])`.
  - S-type: `imm` = `sext({instr[31:25], instr[11:7]})`.
  - Illegal instruction: go to HALT.
- **Legal encodings:**
  - `ld`: opcode 0000011, funct3 011.
  - `sd`: opcode 0100011, funct3 011.
  - `addi`: opcode 0010011, funct3 000.
  - `add`/`sub`: opcode 0110011, funct3 000, funct7 0000000 or 0100000.
- **EXEC:** drive the muxes and `sinal`.
  - `ld`/`sd`/`addi`: `sinalMux1`=0, `sinal`=0.
  - `add`: `sinalMux1`=1, `sinal`=0.
  - `sub`: `sinalMux1`=1, `sinal`=1.
  - `ld`/`sd` go to MEM. `add`/`sub`/`addi` go to WB.
- **MEM:**
  - `sd`: `weMem`=1 for this single cycle, then the instruction retires.
  - `ld`: one read cycle, then WB.
- **WB:** `weReg`=1 for one cycle, suppressed when `Rw`=0 (x0). `sinalMux2`=0 for `ld`, 1 otherwise.
- **Retirement:** happens at the end of WB (or MEM for `sd`). `instret` increments by 1 and wraps from 0xFFFF_FFFF to 0. Next state is FETCH if `run`=1, otherwise IDLE.
- **HALT:** absorbing. All enables are 0 and `halted`=1. Only `rst_n` leaves it.
- **Hold rule:** decoded fields, mux selects and `sinal` stay stable from DECODE until retirement, so they are valid on every enable edge.

## Timing
- **Reset values:** state IDLE; all enables 0; `sinal`, `sinalMux1`, `sinalMux2` = 0; `Ra`/`Rb`/`Rw` = 0; `imm` = 0; `halted` = 0; `instret` = 0.
- All outputs are registered except `pc_next`, which is combinational.
- **Cycle counts, FETCH through retirement:**
  - `ld`: 5 cycles.
  - `sd`, `add`, `sub`, `addi`: 4 cycles.
- Each write enable is high for exactly one cycle per instruction.
- **`run` falling mid-instruction:** the current instruction completes, then the unit goes to IDLE. There is no abort.
- **`run` high at retirement:** the next FETCH follows with no idle cycle.
- **`rst_n` low in any state:** enables drop to 0 immediately, without waiting for a clock edge. No partial write may occur afterwards.
- **Simultaneous reset release and `run`=1:** the first FETCH happens on the second rising edge after release.

## Structure
- **Package `controle_pkg`:**
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_OPIMM`, `OP_OP`;
  - funct3/funct7 constants;
  - the state enum;
  - the opcode-class enum `{C_LD, C_SD, C_ADD, C_SUB, C_ADDI, C_ILL}`.
- **Sub-module `decodificador`:** combinational; maps `instr` to class, rs1, rs2, rd and `imm`. The FSM, counter and output registers live in `unidade_controle`.

## Test plan
- **`ld x1,0(x0)`**, `instr`=0x00003083:
  - `weIR`/`wePC` at cycle 1; `Ra`=0, `Rw`=1, `imm`=0, `sinalMux1`=0.
  - `weReg`=1 and `sinalMux2`=0 at cycle 5; `instret`=1.
- **`add x3,x2,x1`** (0x001101B3), then **`sub x4,x1,x3`** (0x40308233):
  - `add`: `Ra`=2, `Rb`=1, `Rw`=3, `sinalMux1`=1, `sinal`=0.
  - `sub`: `Ra`=1, `Rb`=3, `Rw`=4, `sinal`=1.
  - Both: `sinalMux2`=1; `weReg` in cycle 4 of each.
- **`sd x6,8(x5)`**, 0x0062B423:
  - `Ra`=5, `Rb`=6, `imm`=8; `weMem`=1 for one cycle in cycle 4; `weReg` never asserted.
- **`addi x7,x0,-3`**, 0xFFD00393:
  - `imm`=0xFFFF_FFFF_FFFF_FFFD, `Rw`=7, `sinalMux2`=1.
  - A follow-up `addi x0,x0,1` (0x00100013) produces no `weReg` pulse but `instret` still increments.
- **Illegal 0x00000000:**
  - `halted`=1 after DECODE; no further enables while `run`=1 for 20 cycles.
  - Pulsing `rst_n` low clears `halted` and `instret`.
- **Abort and stall:**
  - Assert `rst_n`=0 during MEM of `sd`: `weMem` drops immediately.
  - Deassert `run` during EXEC of `add`: WB still occurs, then the unit idles; `pc` is not re-fetched.
